seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//   Sequential n-bit unsigned restoring divider (shift-subtract), one quotient bit per clock.
//   Inverse datapath of the shift-add multiplier: remainder/quotient pair shifts left, trial-subtracts divisor.
//   Sits beside the multiplier in the arithmetic unit and is driven by the same top-level controller
//   through a start/done handshake.
// PARAMETERS
//   n  8  operand width; dividend, divisor, quotient, remainder are all n bits
// PORTS
//   clk           input   1  rising-edge clock
//   rst_n         input   1  synchronous reset, active-low, sampled on posedge clk
//   start         input   1  request; sampled only in IDLE
//   dividend      input   n  unsigned dividend, captured when start is accepted
//   divisor       input   n  unsigned divisor, captured when start is accepted
//   busy          output  1  high while in CALC
//   done          output  1  one-cycle pulse, results valid
//   quotient      output  n  result quotient, held until next accepted start
//   remainder     output  n  result remainder, held until next accepted start
//   div_by_zero   output  1  set with done when divisor==0, held with results
// BEHAVIOUR
//   Clock/reset: single clock clk. rst_n is synchronous, active-low; it overrides everything, including mid-operation.
//   Reset values: state=IDLE; busy, done, div_by_zero, quotient, remainder all 0; internal R, Q, D, count all 0.
//   FSM states:
//     IDLE -> CALC  on start & divisor!=0.
//       Load R=0 (n+1 bits), Q=dividend, D=divisor, count=n.
//     IDLE -> DONE  on start & divisor==0.
//       quotient={n{1'b1}}, remainder=dividend, div_by_zero=1.
//     CALC, each edge:
//       R'=(R<<1)|Q[n-1]; Q'=Q<<1;
//       if R'>=D then R'=R'-D, Q'[0]=1; count-=1.
//     CALC -> DONE  on the edge where count goes 1->0.
//       quotient=final Q', remainder=final R'[n-1:0], div_by_zero=0.
//     DONE -> IDLE  unconditionally on next edge.
//   Outputs:
//     done=1 only in DONE (exactly one cycle).
//     busy=1 only in CALC.
//   Latency:
//     start sampled at edge k -> done high in the cycle after edge k+n (n+1 edges after start).
//     Divide-by-zero: done high in the cycle after edge k.
//   Handshake:
//     start ignored in CALC and DONE (no queuing).
//     Back-to-back: next start accepted in the cycle after done.
//     Operands are sampled only at acceptance; changes during CALC have no effect.
//   Result outputs and div_by_zero are registered and change only on the DONE-entry edge or on reset.
//   Arithmetic: R holds n+1 bits so R<<1 never overflows; the comparison is unsigned (n+1)-bit.
//   Boundaries:
//     dividend=0 -> q=0, r=0.
//     dividend<divisor -> q=0, r=dividend.
//     divisor=1 -> q=dividend, r=0.
//     Simultaneous rst_n=0 and start=1 -> reset wins.
// TESTING (n=8)
//   1. rst_n=0 for 2 cycles -> all outputs 0, busy=0; start held high during reset is ignored.
//   2. 100/7 -> busy for 8 cycles, done pulse 9 edges after start, q=14, r=2, dbz=0.
//   3. 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 0/5 -> q=0, r=0.
//   4. 200/0 -> done on next cycle, q=8'hFF, r=200, dbz=1, busy never high.
//   5. start during CALC with new operands -> ignored, first result unchanged.
//      Back-to-back: 50/3 then 9/4 -> (16,2) then (2,1).
//   6. rst_n=0 at 4th CALC cycle -> IDLE next edge, outputs 0, no done.
//      Subsequent 100/7 -> q=14, r=2.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock via shift and trial subtract.
// A zero divisor skips the iteration and reports all-ones quotient with the dividend as remainder.
module seq_restoring_divider #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [n:0]    r_reg;
    logic [n-1:0]  q_reg;
    logic [n-1:0]  d_reg;
    logic [CW-1:0] count_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          dbz_reg;
    logic [n-1:0]  quotient_reg;
    logic [n-1:0]  remainder_reg;

    logic [n:0]    r_shift;
    logic [n:0]    d_ext;
    logic [n:0]    r_diff;
    logic [n+1:0]  borrow;
    logic          ge;
    logic [n:0]    r_next;
    logic [n-1:0]  q_next;

    assign r_shift   = {r_reg[n-1:0], q_reg[n-1]};
    assign d_ext     = {1'b0, d_reg};
    assign borrow[0] = 1'b0;

    // Ripple-borrow trial subtraction; the final borrow doubles as the R' < D flag.
    genvar gi;
    generate
        for (gi = 0; gi <= n; gi++) begin : g_sub
            assign r_diff[gi]   = r_shift[gi] ^ d_ext[gi] ^ borrow[gi];
            assign borrow[gi+1] = (~r_shift[gi] & d_ext[gi]) |
                                  (~(r_shift[gi] ^ d_ext[gi]) & borrow[gi]);
        end
    endgenerate

    // A set top bit of R means R<<1 is at least 2^(n+1), which always exceeds D.
    assign ge     = r_reg[n] | ~borrow[n+1];
    assign r_next = ge ? r_diff : r_shift;

    assign q_next[0] = ge;
    generate
        for (gi = 1; gi < n; gi++) begin : g_qshift
            assign q_next[gi] = q_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            r_reg     <= '0;
                            q_reg     <= dividend;
                            d_reg     <= divisor;
                            count_reg <= CW'(n);
                            busy_reg  <= 1'b1;
                            state_reg <= CALC;
                        end else begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                CALC: begin
                    r_reg     <= r_next;
                    q_reg     <= q_next;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next[n-1:0];
                        dbz_reg       <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: expected results are queued at start
// and compared (values, latency, busy cycles) when done pulses.
module tb_seq_restoring_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    seq_restoring_divider #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           cyc;
        int           busy_cycles;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    logic [N-1:0] last_q   = '0;
    logic [N-1:0] last_r   = '0;
    logic         last_dbz = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one start pulse; when accept is set the DUT is known idle, so queue the model result.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit accept);
        exp_t e;
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (accept) begin
            e.a           = a;
            e.b           = b;
            e.dbz         = (b == '0);
            e.q           = (b == '0) ? {N{1'b1}} : a / b;
            e.r           = (b == '0) ? a : a % b;
            e.cyc         = cyc + 1 + ((b == '0) ? 0 : N);
            e.busy_cycles = (b == '0) ? 0 : N;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    // Monitor: pops the scoreboard on done, otherwise checks that results are held.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            last_q   = '0;
            last_r   = '0;
            last_dbz = 1'b0;
        end else if (done) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d (exp q=%0d r=%0d dbz=%0d) cyc=%0d",
                         e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.dbz, cyc);
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("latency", 32'(cyc), 32'(e.cyc));
                check("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
                check("busy_in_done", 32'(busy), 32'd0);
                last_q   = e.q;
                last_r   = e.r;
                last_dbz = e.dbz;
            end
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            check("hold_q", 32'(quotient), 32'(last_q));
            check("hold_r", 32'(remainder), 32'(last_r));
            check("hold_dbz", 32'(div_by_zero), 32'(last_dbz));
        end
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;

        // Reset with start held high: must stay idle with cleared outputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        start_op(8'd100, 8'd7, 1'b1);
        wait_done();
        start_op(8'd255, 8'd1, 1'b1);
        wait_done();
        start_op(8'd5, 8'd9, 1'b1);
        wait_done();
        start_op(8'd0, 8'd5, 1'b1);
        wait_done();
        start_op(8'd200, 8'd0, 1'b1);
        wait_done();

        // Start during CALC is ignored; then back-to-back acceptance right after done.
        start_op(8'd50, 8'd3, 1'b1);
        start_op(8'd123, 8'd45, 1'b0);
        wait_done();
        start_op(8'd9, 8'd4, 1'b1);
        wait_done();

        // Reset in the 4th CALC cycle aborts the operation with no done.
        start_op(8'd100, 8'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_busy", 32'(busy), 32'd0);
        start_op(8'd100, 8'd7, 1'b1);
        wait_done();

        for (int i = 0; i < 24; i++) begin
            start_op(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), 1'b1);
            wait_done();
        end
        start_op(8'd255, 8'd255, 1'b1);
        wait_done();
        start_op(8'd254, 8'd255, 1'b1);
        wait_done();

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
